// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for the pipelined ARM core: tracks in-flight destination
// registers after decode and turns decode-stage sources into forward selects or stalls.
module hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int REG_W    = 4,
    parameter int LOAD_LAT = 1,
    parameter int FORWARD  = 1,
    parameter int FLUSH_N  = 1,
    parameter int PC_REG   = 15,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_rn,
    input  logic                       id_rn_used,
    input  logic [REG_W-1:0]           id_rm,
    input  logic                       id_rm_used,
    input  logic [REG_W-1:0]           id_rs,
    input  logic                       id_rs_used,
    input  logic                       id_wr_en,
    input  logic [REG_W-1:0]           id_wr_reg,
    input  logic                       id_is_load,
    input  logic                       flush,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rn,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rm,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int FW = $clog2(DEPTH+1);
    localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0][REG_W-1:0] reg_q, reg_d;
    logic [DEPTH-1:0]            ld_q, ld_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [FW:0] rn_res_s, rm_res_s, rs_res_s;
    logic        stall_s;

    // Returns {hazard, fwd_select}; the youngest matching entry decides, older ones are ignored.
    function automatic logic [FW:0] lookup_f(
        input logic [REG_W-1:0]            src,
        input logic                        used,
        input logic                        valid,
        input logic [DEPTH-1:0]            v,
        input logic [DEPTH-1:0][REG_W-1:0] regs,
        input logic [DEPTH-1:0]            ld
    );
        logic          haz;
        logic          found;
        logic [FW-1:0] fwd;
        haz   = 1'b0;
        found = 1'b0;
        fwd   = {FW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && valid && used && v[i] && (regs[i] == src) && (src != PC_IDX)) begin
                found = 1'b1;
                if (FORWARD == 0) begin
                    haz = 1'b1;
                end else if (ld[i] && (i < LOAD_LAT)) begin
                    haz = 1'b1;
                end else begin
                    fwd = FW'(i + 1);
                end
            end else begin
                found = found;
            end
        end
        return {haz, fwd};
    endfunction

    // Source lookup, stall decision and forward selects (zero-cycle, from current entries).
    always_comb begin
        rn_res_s = lookup_f(id_rn, id_rn_used, id_valid, v_q, reg_q, ld_q);
        rm_res_s = lookup_f(id_rm, id_rm_used, id_valid, v_q, reg_q, ld_q);
        rs_res_s = lookup_f(id_rs, id_rs_used, id_valid, v_q, reg_q, ld_q);
        stall_s  = (rn_res_s[FW] | rm_res_s[FW] | rs_res_s[FW]) & ~flush;
        stall    = stall_s;
        if (stall_s) begin
            fwd_rn = {FW{1'b0}};
            fwd_rm = {FW{1'b0}};
            fwd_rs = {FW{1'b0}};
        end else begin
            fwd_rn = rn_res_s[FW-1:0];
            fwd_rm = rm_res_s[FW-1:0];
            fwd_rs = rs_res_s[FW-1:0];
        end
    end

    // Next scoreboard contents: shift toward the oldest slot, bubble on stall/flush.
    always_comb begin
        v_d      = v_q;
        reg_d    = reg_q;
        ld_d     = ld_q;
        v_d[0]   = id_valid & id_wr_en & (id_wr_reg != PC_IDX) & ~stall_s & ~flush;
        reg_d[0] = id_wr_reg;
        ld_d[0]  = id_is_load;
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i]   = v_q[i-1] & ~(flush & (i < FLUSH_N));
            reg_d[i] = reg_q[i-1];
            ld_d[i]  = ld_q[i-1];
        end
        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset clears every entry so a pending stall drops immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q   <= {DEPTH{1'b0}};
            reg_q <= '0;
            ld_q  <= {DEPTH{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            v_q   <= v_d;
            reg_q <= reg_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a bypassing instance (A) and a stall-only
// instance with a 2-bit counter (B) share stimulus; expectations are queued per cycle.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld_a, vld_b;
    logic [3:0] rn, rm, rs, wr;
    logic       rnu, rmu, rsu, we, isld, fl;

    logic        a_stall, b_stall;
    logic [1:0]  a_rn, a_rm, a_rs, b_rn, b_rm, b_rs;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    typedef struct {
        string       name;
        bit          selb;
        logic        stall;
        logic [1:0]  frn, frm, frs;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_a (
        .clk(clk), .reset_n(rst_n), .id_valid(vld_a),
        .id_rn(rn), .id_rn_used(rnu), .id_rm(rm), .id_rm_used(rmu),
        .id_rs(rs), .id_rs_used(rsu), .id_wr_en(we), .id_wr_reg(wr),
        .id_is_load(isld), .flush(fl), .stall(a_stall),
        .fwd_rn(a_rn), .fwd_rm(a_rm), .fwd_rs(a_rs), .stall_cnt(a_cnt)
    );

    hazard_scoreboard #(.FORWARD(0), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(rst_n), .id_valid(vld_b),
        .id_rn(rn), .id_rn_used(rnu), .id_rm(rm), .id_rm_used(rmu),
        .id_rs(rs), .id_rs_used(rsu), .id_wr_en(we), .id_wr_reg(wr),
        .id_is_load(isld), .flush(fl), .stall(b_stall),
        .fwd_rn(b_rn), .fwd_rm(b_rm), .fwd_rs(b_rs), .stall_cnt(b_cnt)
    );

    task automatic cmp(input string name, input string fld, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, checked mid-cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.selb) begin
                cmp(e.name, "stall", int'(a_stall), int'(e.stall));
                cmp(e.name, "fwd_rn", int'(a_rn), int'(e.frn));
                cmp(e.name, "fwd_rm", int'(a_rm), int'(e.frm));
                cmp(e.name, "fwd_rs", int'(a_rs), int'(e.frs));
                cmp(e.name, "stall_cnt", int'(a_cnt), int'(e.cnt));
            end else begin
                cmp(e.name, "stall", int'(b_stall), int'(e.stall));
                cmp(e.name, "fwd_rn", int'(b_rn), int'(e.frn));
                cmp(e.name, "fwd_rm", int'(b_rm), int'(e.frm));
                cmp(e.name, "fwd_rs", int'(b_rs), int'(e.frs));
                cmp(e.name, "stall_cnt", int'(b_cnt), int'(e.cnt));
            end
        end
    end

    task automatic op(input bit to_b, input bit v, input bit w, input logic [3:0] wreg,
                      input bit ld, input bit ru, input logic [3:0] r_n,
                      input bit mu, input logic [3:0] r_m, input bit su,
                      input logic [3:0] r_s, input bit f);
        vld_a = v & ~to_b;
        vld_b = v & to_b;
        we    = w;
        wr    = wreg;
        isld  = ld;
        rnu   = ru;
        rn    = r_n;
        rmu   = mu;
        rm    = r_m;
        rsu   = su;
        rs    = r_s;
        fl    = f;
    endtask

    task automatic exp_a(input string name, input logic st, input logic [1:0] frn,
                         input logic [1:0] frm, input logic [1:0] frs, input logic [15:0] c);
        exp_t e;
        e.name = name; e.selb = 1'b0; e.stall = st;
        e.frn = frn; e.frm = frm; e.frs = frs; e.cnt = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_b(input string name, input logic st, input logic [15:0] c);
        exp_t e;
        e.name = name; e.selb = 1'b1; e.stall = st;
        e.frn = 2'd0; e.frm = 2'd0; e.frs = 2'd0; e.cnt = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        op(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_a("rst_a", 1'b0, 2'd0, 2'd0, 2'd0, 16'd0); tick();
        exp_b("rst_b", 1'b0, 16'd0); tick();
        rst_n = 1'b1; tick();

        // Bypass distance, duplicate sources, youngest-wins
        op(1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
        exp_a("add_r4", 1'b0, 2'd0, 2'd0, 2'd0, 16'd0); tick();
        op(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_a("fwd_e0", 1'b0, 2'd1, 2'd0, 2'd0, 16'd0); tick();
        op(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        exp_a("fwd_e1_dup", 1'b0, 2'd2, 2'd2, 2'd0, 16'd0); tick();
        op(1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_a("fwd_e2", 1'b0, 2'd3, 2'd0, 2'd0, 16'd0); tick();
        op(1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_a("r7_e0", 1'b0, 2'd1, 2'd0, 2'd0, 16'd0); tick();
        op(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 4'd3, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        exp_a("youngest", 1'b0, 2'd3, 2'd1, 2'd0, 16'd0); tick();

        // Load-use stall, then forward from entry 1
        op(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_a("ldr_r5", 1'b0, 2'd1, 2'd0, 2'd0, 16'd0); tick();
        op(1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 4'd5, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        exp_a("load_use", 1'b1, 2'd0, 2'd0, 2'd0, 16'd0); tick();
        exp_a("after_stall", 1'b0, 2'd2, 2'd0, 2'd0, 16'd1); tick();

        // Flush beats stall; flushed-cycle load keeps shifting with FLUSH_N=1
        op(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_a("ldr_r5b", 1'b0, 2'd0, 2'd0, 2'd0, 16'd1); tick();
        op(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1);
        exp_a("flush_beats", 1'b0, 2'd0, 2'd0, 2'd0, 16'd1); tick();
        op(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
        exp_a("str_after_flush", 1'b0, 2'd2, 2'd0, 2'd3, 16'd1); tick();

        // PC register is never a hazard source or destination
        op(1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        exp_a("pc_dst", 1'b0, 2'd0, 2'd3, 2'd0, 16'd1); tick();
        op(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 4'd15, 1'b0);
        exp_a("pc_src", 1'b0, 2'd0, 2'd0, 2'd0, 16'd1); tick();

        // No-forward instance: a match stalls until the writer retires; counter saturates
        op(1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_b("b_add_r1", 1'b0, 16'd0); tick();
        op(1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_b("b_stall1", 1'b1, 16'd0); tick();
        exp_b("b_stall2", 1'b1, 16'd1); tick();
        exp_b("b_stall3", 1'b1, 16'd2); tick();
        exp_b("b_release", 1'b0, 16'd3); tick();
        op(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_b("b_stall_r2", 1'b1, 16'd3); tick();
        exp_b("b_cnt_sat", 1'b1, 16'd3); tick();

        // Asynchronous reset while a stall is pending
        rst_n = 1'b0;
        exp_b("b_async_rst", 1'b0, 16'd0); tick();
        rst_n = 1'b1;
        exp_b("b_post_rst", 1'b0, 16'd0); tick();
        op(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        exp_a("a_post_rst", 1'b0, 2'd0, 2'd0, 2'd0, 16'd0); tick();

        op(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
